// File: rtl/i2s_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_fifo_pkg
//  Brief    : Shared constants and types for the I2S stereo sample FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package i2s_fifo_pkg;

    localparam int c_depth_log2_default = 4;

    // Bit positions inside the sticky error flag vector.
    localparam int c_flag_overflow = 0;
    localparam int c_flag_underrun = 1;
    localparam int c_flag_count    = 2;

    typedef struct packed {
        logic [31:0] left;
        logic [31:0] right;
    } stereo_pair_t;

endpackage : i2s_fifo_pkg
`default_nettype wire

// File: rtl/i2s_sample_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_sample_fifo_if
//  Brief    : Bus-side / serializer-side signal bundle of the sample FIFO.
//             I2S_SAMPLE_FIFO_IRQ_EN adds the threshold interrupt signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface i2s_sample_fifo_if #(
    parameter int IRQ_LEVEL_W = 5
);
    logic [31:0]            wr_data_i;
    logic                   wr_left_we_i;
    logic                   wr_right_we_i;
    logic                   flush_i;
    logic                   clr_err_i;
    logic                   fifo_ack;
    logic                   fifo_ready;
    logic [31:0]            fifo_left_data;
    logic [31:0]            fifo_right_data;
    logic [IRQ_LEVEL_W-1:0] level_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   overflow_o;
    logic                   underrun_o;

`ifdef I2S_SAMPLE_FIFO_IRQ_EN
    logic [IRQ_LEVEL_W-1:0] irq_thresh_i;
    logic                   irq_o;

    modport master (
        output wr_data_i, wr_left_we_i, wr_right_we_i, flush_i, clr_err_i,
               fifo_ack, irq_thresh_i,
        input  fifo_ready, fifo_left_data, fifo_right_data, level_o,
               full_o, empty_o, overflow_o, underrun_o, irq_o
    );

    modport slave (
        input  wr_data_i, wr_left_we_i, wr_right_we_i, flush_i, clr_err_i,
               fifo_ack, irq_thresh_i,
        output fifo_ready, fifo_left_data, fifo_right_data, level_o,
               full_o, empty_o, overflow_o, underrun_o, irq_o
    );
`else
    modport master (
        output wr_data_i, wr_left_we_i, wr_right_we_i, flush_i, clr_err_i,
               fifo_ack,
        input  fifo_ready, fifo_left_data, fifo_right_data, level_o,
               full_o, empty_o, overflow_o, underrun_o
    );

    modport slave (
        input  wr_data_i, wr_left_we_i, wr_right_we_i, flush_i, clr_err_i,
               fifo_ack,
        output fifo_ready, fifo_left_data, fifo_right_data, level_o,
               full_o, empty_o, overflow_o, underrun_o
    );
`endif

endinterface : i2s_sample_fifo_if
`default_nettype wire

// File: rtl/i2s_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_fifo_ram
//  Brief    : Stereo-pair storage, one synchronous write port and one
//             asynchronous read port. Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_fifo_ram
    import i2s_fifo_pkg::*;
#(
    parameter int ADDR_W = c_depth_log2_default
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire stereo_pair_t      i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output stereo_pair_t           o_rdata
);

    stereo_pair_t r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : i2s_fifo_ram
`default_nettype wire

// File: rtl/i2s_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_sample_fifo
//  Brief    : Stereo sample FIFO between a register bus and an I2S serializer.
//             Optional level interrupt enabled by I2S_SAMPLE_FIFO_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_fifo
    import i2s_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = c_depth_log2_default,
    parameter int IRQ_LEVEL_W = DEPTH_LOG2 + 1
) (
    input  wire logic         i2s_clk_i,
    input  wire logic         i2s_rst_ni,
    i2s_sample_fifo_if.slave  bus
);

    localparam int c_ptr_w = DEPTH_LOG2 + 1;

    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [31:0]             r_staging;
    logic [c_flag_count-1:0] r_flags;

    logic [c_ptr_w-1:0]      w_level;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_push_ok;
    logic                    w_pop_ok;
    logic                    w_mem_we;
    logic [c_flag_count-1:0] w_flag_set;
    stereo_pair_t            w_wr_pair;
    stereo_pair_t            w_rd_pair;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_level = r_wr_ptr - r_rd_ptr;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign w_pop_ok  = bus.fifo_ack && !w_empty;
    assign w_push_ok = bus.wr_right_we_i && (!w_full || bus.fifo_ack);
    assign w_mem_we  = w_push_ok && !bus.flush_i;

    // Both strobes together mean a mono sample duplicated into both channels.
    assign w_wr_pair.left  = bus.wr_left_we_i ? bus.wr_data_i : r_staging;
    assign w_wr_pair.right = bus.wr_data_i;

    always_comb begin
        w_flag_set                  = '0;
        w_flag_set[c_flag_overflow] = !bus.flush_i && bus.wr_right_we_i &&
                                      w_full && !bus.fifo_ack;
        w_flag_set[c_flag_underrun] = !bus.flush_i && bus.fifo_ack && w_empty;
    end

    always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
        if (!i2s_rst_ni) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_staging <= '0;
            r_flags   <= '0;
        end else begin
            if (bus.flush_i) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_staging <= '0;
            end else begin
                if (bus.wr_left_we_i) begin
                    r_staging <= bus.wr_data_i;
                end
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            // Set events win over a same-cycle clear.
            r_flags <= w_flag_set | (r_flags & ~{c_flag_count{bus.clr_err_i}});
        end
    end

    i2s_fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (i2s_clk_i),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (w_wr_pair),
        .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rd_pair)
    );

    assign bus.fifo_ready      = !w_empty;
    assign bus.fifo_left_data  = w_rd_pair.left;
    assign bus.fifo_right_data = w_rd_pair.right;
    assign bus.level_o         = IRQ_LEVEL_W'(w_level);
    assign bus.full_o          = w_full;
    assign bus.empty_o         = w_empty;
    assign bus.overflow_o      = r_flags[c_flag_overflow];
    assign bus.underrun_o      = r_flags[c_flag_underrun];

`ifdef I2S_SAMPLE_FIFO_IRQ_EN
    logic                   r_irq_armed;
    logic                   r_irq;
    logic [IRQ_LEVEL_W-1:0] w_level_ext;

    assign w_level_ext = IRQ_LEVEL_W'(w_level);

    // The interrupt stays quiet until the FIFO has been primed at least once.
    always_ff @(posedge i2s_clk_i or negedge i2s_rst_ni) begin
        if (!i2s_rst_ni) begin
            r_irq_armed <= 1'b0;
            r_irq       <= 1'b0;
        end else if (bus.flush_i) begin
            r_irq_armed <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_irq_armed <= 1'b1;
            end
            r_irq <= r_irq_armed && (w_level_ext <= bus.irq_thresh_i);
        end
    end

    assign bus.irq_o = r_irq;
`else
    // Interrupt logic is not built in this configuration.
`endif

endmodule : i2s_sample_fifo
`default_nettype wire

// File: tb/tb_i2s_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_sample_fifo
//  Brief    : Directed, table-driven bench for i2s_sample_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_fifo;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    i2s_sample_fifo_if #(.IRQ_LEVEL_W(5)) bus ();

    i2s_sample_fifo #(
        .DEPTH_LOG2  (4),
        .IRQ_LEVEL_W (5)
    ) dut (
        .i2s_clk_i  (clk),
        .i2s_rst_ni (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lw, rw, ack, fl, clr;
        logic [31:0] data;
        logic        ready;
        logic [31:0] eleft, eright;
        logic [4:0]  level;
        logic        full, empty, ovf, und;
    } vec_t;

    vec_t        vecs [15];
    logic [63:0] q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_left_we_i  = 1'b0;
        bus.wr_right_we_i = 1'b0;
        bus.fifo_ack      = 1'b0;
        bus.flush_i       = 1'b0;
        bus.clr_err_i     = 1'b0;
        bus.wr_data_i     = '0;
    endtask

    task automatic mono_push(input logic [31:0] d, input logic ack);
        bus.wr_left_we_i  = 1'b1;
        bus.wr_right_we_i = 1'b1;
        bus.fifo_ack      = ack;
        bus.wr_data_i     = d;
        tick();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
`ifdef I2S_SAMPLE_FIFO_IRQ_EN
        bus.irq_thresh_i = 5'd4;
`endif
        //        lw rw ak fl cl data          rdy left          right         lvl full emp ovf und
        vecs[0]  = '{1,0,0,0,0, 32'h1111_0000, 0, 32'h0,        32'h0,        0, 0,1,0,0};
        vecs[1]  = '{0,1,0,0,0, 32'h2222_0000, 1, 32'h1111_0000, 32'h2222_0000, 1, 0,0,0,0};
        vecs[2]  = '{1,1,0,0,0, 32'hAAAA_5555, 1, 32'h1111_0000, 32'h2222_0000, 2, 0,0,0,0};
        vecs[3]  = '{0,0,1,0,0, 32'h0,         1, 32'hAAAA_5555, 32'hAAAA_5555, 1, 0,0,0,0};
        vecs[4]  = '{0,0,1,0,0, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,0};
        vecs[5]  = '{0,0,1,0,0, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,1};
        vecs[6]  = '{0,0,0,0,1, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,0};
        vecs[7]  = '{0,0,1,0,1, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,1};
        vecs[8]  = '{0,0,0,0,1, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,0};
        vecs[9]  = '{1,0,0,0,0, 32'h3333_0000, 0, 32'h0,        32'h0,        0, 0,1,0,0};
        vecs[10] = '{0,1,1,0,0, 32'h4444_0000, 1, 32'h3333_0000, 32'h4444_0000, 1, 0,0,0,1};
        vecs[11] = '{0,1,0,1,0, 32'h5555_0000, 0, 32'h0,        32'h0,        0, 0,1,0,1};
        vecs[12] = '{0,0,0,0,1, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,0};
        vecs[13] = '{0,1,0,0,0, 32'h6666_0000, 1, 32'h0,        32'h6666_0000, 1, 0,0,0,0};
        vecs[14] = '{0,0,0,1,0, 32'h0,         0, 32'h0,        32'h0,        0, 0,1,0,0};

        // Reset state
        #3;
        check("rst_ready", bus.fifo_ready, 0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_full",  bus.full_o, 0);
        check("rst_level", bus.level_o, 0);
        check("rst_ovf",   bus.overflow_o, 0);
        check("rst_und",   bus.underrun_o, 0);
`ifdef I2S_SAMPLE_FIFO_IRQ_EN
        check("rst_irq",   bus.irq_o, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 15; i++) begin
            bus.wr_left_we_i  = vecs[i].lw;
            bus.wr_right_we_i = vecs[i].rw;
            bus.fifo_ack      = vecs[i].ack;
            bus.flush_i       = vecs[i].fl;
            bus.clr_err_i     = vecs[i].clr;
            bus.wr_data_i     = vecs[i].data;
            tick();
            idle();
            check($sformatf("v%0d_ready", i), bus.fifo_ready, vecs[i].ready);
            check($sformatf("v%0d_level", i), bus.level_o, vecs[i].level);
            check($sformatf("v%0d_full", i),  bus.full_o, vecs[i].full);
            check($sformatf("v%0d_empty", i), bus.empty_o, vecs[i].empty);
            check($sformatf("v%0d_ovf", i),   bus.overflow_o, vecs[i].ovf);
            check($sformatf("v%0d_und", i),   bus.underrun_o, vecs[i].und);
            if (vecs[i].ready) begin
                check($sformatf("v%0d_left", i),  bus.fifo_left_data, vecs[i].eleft);
                check($sformatf("v%0d_right", i), bus.fifo_right_data, vecs[i].eright);
            end
        end

        // Fill to full, then overflow
        q.delete();
        for (int i = 0; i < 16; i++) begin
            bus.wr_left_we_i = 1'b1;
            bus.wr_data_i    = 32'h1000_0000 + i;
            tick();
            idle();
            bus.wr_right_we_i = 1'b1;
            bus.wr_data_i     = 32'h2000_0000 + i;
            tick();
            idle();
            q.push_back({32'h1000_0000 + i, 32'h2000_0000 + i});
        end
        check("fill_level", bus.level_o, 16);
        check("fill_full",  bus.full_o, 1);
        check("fill_ovf",   bus.overflow_o, 0);
        bus.wr_right_we_i = 1'b1;
        bus.wr_data_i     = 32'hDEAD_0000;
        tick();
        idle();
        check("ovf_level", bus.level_o, 16);
        check("ovf_full",  bus.full_o, 1);
        check("ovf_flag",  bus.overflow_o, 1);
        check("ovf_head",  {bus.fifo_left_data, bus.fifo_right_data}, {32'h1000_0000, 32'h2000_0000});

        // Push and pop together while full, wrapping the pointers
        for (int k = 0; k < 41; k++) begin
            mono_push(32'h3000_0000 + k, 1'b1);
            void'(q.pop_front());
            q.push_back({32'h3000_0000 + k, 32'h3000_0000 + k});
            check($sformatf("sim%0d_level", k), bus.level_o, 16);
            check($sformatf("sim%0d_head", k), {bus.fifo_left_data, bus.fifo_right_data}, q[0]);
        end

        // Drain in order
        while (q.size() > 0) begin
            bus.fifo_ack = 1'b1;
            tick();
            idle();
            void'(q.pop_front());
            check("drain_level", bus.level_o, q.size());
            if (q.size() > 0)
                check("drain_head", {bus.fifo_left_data, bus.fifo_right_data}, q[0]);
        end
        check("drain_ready", bus.fifo_ready, 0);
        check("drain_und",   bus.underrun_o, 0);

`ifdef I2S_SAMPLE_FIFO_IRQ_EN
        for (int i = 0; i < 8; i++) mono_push(32'h5000_0000 + i, 1'b0);
        tick();
        check("irq_level8", bus.level_o, 8);
        check("irq_hi_lvl", bus.irq_o, 0);
        for (int i = 0; i < 4; i++) begin
            bus.fifo_ack = 1'b1;
            tick();
            idle();
        end
        check("irq_level4", bus.level_o, 4);
        check("irq_before", bus.irq_o, 0);
        tick();
        check("irq_raised", bus.irq_o, 1);
        bus.flush_i = 1'b1;
        tick();
        idle();
        check("irq_flush", bus.irq_o, 0);
        tick();
        check("irq_idle",  bus.irq_o, 0);
`endif

        // Asynchronous reset with stored pairs
        bus.flush_i = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) mono_push(32'h6000_0000 + i, 1'b0);
        check("pre_rst_level", bus.level_o, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", bus.empty_o, 1);
        check("arst_level", bus.level_o, 0);
        check("arst_ready", bus.fifo_ready, 0);
        check("arst_ovf",   bus.overflow_o, 0);
        tick();
        rst_n = 1'b1;
        bus.wr_right_we_i = 1'b1;
        bus.wr_data_i     = 32'h7777_0000;
        tick();
        idle();
        check("post_rst_level", bus.level_o, 1);
        check("post_rst_head",  {bus.fifo_left_data, bus.fifo_right_data}, {32'h0, 32'h7777_0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_i2s_sample_fifo
`default_nettype wire
